// File: rtl/streebog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : streebog_pkg
//  Purpose  : Shared constants, state type and padding helper for the
//             Streebog message packer.
//  Contents : BLOCK_WIDTH / LEN_WIDTH / N_FULL, packer_state_t,
//             pad_bit_mask(len)
//  Revision : 1.0 - initial release
// ============================================================================
package streebog_pkg;

    localparam int BLOCK_WIDTH = 512;
    localparam int LEN_WIDTH   = 10;
    localparam int N_FULL      = 512;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } packer_state_t;

    // One-hot vector with bit 'len' set; all zeros once len reaches a full
    // block, which is exactly the case where the pad bit moves to an extra block.
    function automatic logic [BLOCK_WIDTH-1:0] pad_bit_mask(input logic [LEN_WIDTH-1:0] len);
        logic [BLOCK_WIDTH-1:0] mask;
        mask = '0;
        if (len < LEN_WIDTH'(N_FULL)) begin
            mask[len[$clog2(BLOCK_WIDTH)-1:0]] = 1'b1;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/streebog_msg_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : streebog_msg_packer_if
//  Purpose  : Bundles the packer's input beat stream, output block stream and
//             message control/status into one interface.
//  Modports : slave  - the packer (consumes beats, produces blocks)
//             master - the environment (produces beats, consumes blocks)
//  Revision : 1.0 - initial release
// ============================================================================
interface streebog_msg_packer_if #(
    parameter int IN_WIDTH = 64
);
    import streebog_pkg::*;

    localparam int KW = $clog2(IN_WIDTH/8) + 1;

    logic                   abort_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [IN_WIDTH-1:0]    in_data_i;
    logic                   in_last_i;
    logic [KW-1:0]          in_bytes_i;
    logic                   blk_valid_o;
    logic                   blk_ready_i;
    logic [BLOCK_WIDTH-1:0] blk_data_o;
    logic                   blk_last_o;
    logic [LEN_WIDTH-1:0]   blk_len_o;
    logic                   msg_active_o;

    modport slave (
        input  abort_i, in_valid_i, in_data_i, in_last_i, in_bytes_i, blk_ready_i,
        output in_ready_o, blk_valid_o, blk_data_o, blk_last_o, blk_len_o, msg_active_o
    );

    modport master (
        output abort_i, in_valid_i, in_data_i, in_last_i, in_bytes_i, blk_ready_i,
        input  in_ready_o, blk_valid_o, blk_data_o, blk_last_o, blk_len_o, msg_active_o
    );

endinterface
`default_nettype wire

// File: rtl/streebog_lane_mask.sv
`default_nettype none
// ============================================================================
//  Module   : streebog_lane_mask
//  Purpose  : Combinational byte-lane cleanup of an input beat. On the final
//             beat, lanes at or above the byte count are zeroed and the byte
//             count is saturated to the beat width; other beats pass whole.
//  Ports    : data_i/last_i/bytes_i - raw beat, last flag, byte count
//             data_o/bytes_o        - masked beat, effective byte count
//  Revision : 1.0 - initial release
// ============================================================================
module streebog_lane_mask #(
    parameter int IN_WIDTH = 64,
    parameter int KW       = $clog2(IN_WIDTH/8) + 1
) (
    input  wire logic [IN_WIDTH-1:0] data_i,
    input  wire logic                last_i,
    input  wire logic [KW-1:0]       bytes_i,
    output logic      [IN_WIDTH-1:0] data_o,
    output logic      [KW-1:0]       bytes_o
);

    localparam int            NB   = IN_WIDTH / 8;
    localparam logic [KW-1:0] NB_K = KW'(NB);

    // Non-final beats always count as full so the length arithmetic downstream
    // can use bytes_o unconditionally.
    always_comb begin
        bytes_o = NB_K;
        if (last_i && (bytes_i < NB_K)) begin
            bytes_o = bytes_i;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign data_o[8*g +: 8] = (KW'(g) < bytes_o) ? data_i[8*g +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/streebog_msg_packer.sv
`default_nettype none
// ============================================================================
//  Module   : streebog_msg_packer
//  Purpose  : Assembles a byte-granular beat stream into 512-bit blocks and
//             applies GOST 34.11-2012 padding (bit 1 at position len) to the
//             final block, adding an all-padding block when the message is a
//             multiple of 512 bits.
//  Ports    : clk_i  - clock
//             rstn_i - asynchronous active-low reset
//             bus    - streebog_msg_packer_if.slave (beats in, blocks out,
//                      abort, msg_active)
//  Revision : 1.0 - initial release
// ============================================================================
module streebog_msg_packer
    import streebog_pkg::*;
#(
    parameter int IN_WIDTH = 64
) (
    input wire logic              clk_i,
    input wire logic              rstn_i,
    streebog_msg_packer_if.slave  bus
);

    localparam int BEATS = BLOCK_WIDTH / IN_WIDTH;
    localparam int KW    = $clog2(IN_WIDTH/8) + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0]        LAST_SLOT = CW'(BEATS - 1);
    localparam logic [LEN_WIDTH-1:0] FULL_LEN  = LEN_WIDTH'(N_FULL);

    packer_state_t          r_state;
    logic [BLOCK_WIDTH-1:0] r_buf;
    logic [CW-1:0]          r_beat_cnt;
    logic                   r_pad_pending;
    logic                   r_last;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_in_ready;
    logic                   r_blk_valid;
    logic                   r_msg_active;

    logic [IN_WIDTH-1:0]    w_data;
    logic [KW-1:0]          w_bytes;
    logic [LEN_WIDTH-1:0]   w_slot_off;
    logic [LEN_WIDTH-1:0]   w_len;
    logic [BLOCK_WIDTH-1:0] w_slot_blk;
    logic                   w_in_fire;
    logic                   w_blk_fire;

    streebog_lane_mask #(
        .IN_WIDTH (IN_WIDTH),
        .KW       (KW)
    ) u_lane_mask (
        .data_i  (bus.in_data_i),
        .last_i  (bus.in_last_i),
        .bytes_i (bus.in_bytes_i),
        .data_o  (w_data),
        .bytes_o (w_bytes)
    );

    assign w_slot_off = LEN_WIDTH'(r_beat_cnt) * LEN_WIDTH'(IN_WIDTH);
    assign w_len      = w_slot_off + (LEN_WIDTH'(w_bytes) << 3);
    assign w_slot_blk = BLOCK_WIDTH'(w_data) << w_slot_off;

    // Abort suppresses both handshakes in the cycle it is asserted.
    assign w_in_fire  = bus.in_valid_i & r_in_ready  & ~bus.abort_i;
    assign w_blk_fire = r_blk_valid  & bus.blk_ready_i & ~bus.abort_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= FILL;
            r_buf         <= '0;
            r_beat_cnt    <= '0;
            r_pad_pending <= 1'b0;
            r_last        <= 1'b0;
            r_len         <= '0;
            r_in_ready    <= 1'b0;
            r_blk_valid   <= 1'b0;
            r_msg_active  <= 1'b0;
        end else if (bus.abort_i) begin
            r_state       <= FILL;
            r_buf         <= '0;
            r_beat_cnt    <= '0;
            r_pad_pending <= 1'b0;
            r_last        <= 1'b0;
            r_len         <= '0;
            r_in_ready    <= 1'b1;
            r_blk_valid   <= 1'b0;
            r_msg_active  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    // Ready comes up one cycle after reset release and stays
                    // high in FILL until a block completes.
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_msg_active <= 1'b1;
                        if (bus.in_last_i) begin
                            // The pad mask is empty when len hits a full block;
                            // the pad bit then goes out in EMIT_PAD instead.
                            r_buf       <= r_buf | w_slot_blk | pad_bit_mask(w_len);
                            r_in_ready  <= 1'b0;
                            r_blk_valid <= 1'b1;
                            r_state     <= EMIT;
                            if (w_len == FULL_LEN) begin
                                r_last        <= 1'b0;
                                r_len         <= FULL_LEN;
                                r_pad_pending <= 1'b1;
                            end else begin
                                r_last <= 1'b1;
                                r_len  <= w_len;
                            end
                        end else begin
                            r_buf <= r_buf | w_slot_blk;
                            if (r_beat_cnt == LAST_SLOT) begin
                                r_in_ready  <= 1'b0;
                                r_blk_valid <= 1'b1;
                                r_last      <= 1'b0;
                                r_len       <= FULL_LEN;
                                r_state     <= EMIT;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 1'b1;
                            end
                        end
                    end
                end

                EMIT: begin
                    if (w_blk_fire) begin
                        r_beat_cnt <= '0;
                        if (r_pad_pending) begin
                            // Reuse the buffer as the registered pad-only block.
                            r_buf   <= BLOCK_WIDTH'(1);
                            r_len   <= '0;
                            r_last  <= 1'b1;
                            r_state <= EMIT_PAD;
                        end else begin
                            r_buf       <= '0;
                            r_len       <= '0;
                            r_last      <= 1'b0;
                            r_blk_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= FILL;
                            if (r_last) begin
                                r_msg_active <= 1'b0;
                            end
                        end
                    end
                end

                EMIT_PAD: begin
                    if (w_blk_fire) begin
                        r_pad_pending <= 1'b0;
                        r_buf         <= '0;
                        r_len         <= '0;
                        r_last        <= 1'b0;
                        r_blk_valid   <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_msg_active  <= 1'b0;
                        r_state       <= FILL;
                    end
                end

                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign bus.in_ready_o   = r_in_ready;
    assign bus.blk_valid_o  = r_blk_valid;
    assign bus.blk_data_o   = r_buf;
    assign bus.blk_last_o   = r_last;
    assign bus.blk_len_o    = r_len;
    assign bus.msg_active_o = r_msg_active;

endmodule
`default_nettype wire
